// File: rtl/pcm_fifo_ctrl.sv
// PCM record/playback sequencer in front of a strobe-driven sample FIFO.
// Optional macro PCM_FIFO_CTRL_DROP_CNT_EN adds the drop_cnt output.
module pcm_fifo_ctrl #(
  parameter int unsigned dbits   = 8,
  parameter int unsigned abits   = 6,
  parameter int unsigned STB_CYC = 2,
  parameter int unsigned SETTLE  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rec_start,
  input  logic             play_start,
  input  logic             stop,
  input  logic [dbits-1:0] sample_in,
  input  logic             sample_valid,
  input  logic             play_tick,
  output logic             fifo_wr,
  output logic             fifo_rd,
  output logic [dbits-1:0] fifo_din,
  input  logic [dbits-1:0] fifo_dout,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  output logic [dbits-1:0] sample_out,
  output logic             sample_out_valid,
  output logic [1:0]       mode,
  output logic [abits:0]   sample_count,
  output logic             rec_done,
  output logic             play_done
`ifdef PCM_FIFO_CTRL_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StRecWait    = 3'd1;
  localparam logic [2:0] StRecStb     = 3'd2;
  localparam logic [2:0] StRecSettle  = 3'd3;
  localparam logic [2:0] StPlayWait   = 3'd4;
  localparam logic [2:0] StPlayStb    = 3'd5;
  localparam logic [2:0] StPlaySettle = 3'd6;

  localparam int unsigned CW = $clog2(STB_CYC + SETTLE + 1);
  localparam logic [CW-1:0] StbLast    = CW'(STB_CYC - 1);
  localparam logic [CW-1:0] SettleLast = CW'(SETTLE - 1);
  localparam logic [abits:0] CntMax    = {1'b1, {abits{1'b0}}};

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             stop_pend_q, stop_pend_d;
  logic [dbits-1:0] din_q, din_d;
  logic [abits:0]   count_q, count_d;
  logic [dbits-1:0] sout_q, sout_d;
  logic             sout_vld_q, sout_vld_d;
  logic             rec_done_q, rec_done_d;
  logic             play_done_q, play_done_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    din_d       = din_q;
    count_d     = count_q;
    sout_d      = sout_q;
    sout_vld_d  = 1'b0;
    rec_done_d  = 1'b0;
    play_done_d = 1'b0;
    case (state_q)
      StIdle: begin
        stop_pend_d = 1'b0;
        cnt_d       = '0;
        if (!stop) begin
          if (rec_start) begin
            state_d = StRecWait;
          end else if (play_start) begin
            if (fifo_empty) play_done_d = 1'b1;
            else            state_d     = StPlayWait;
          end
        end
      end
      StRecWait: begin
        stop_pend_d = 1'b0;
        cnt_d       = '0;
        if (fifo_full) begin
          rec_done_d = 1'b1;
          state_d    = StIdle;
        end else if (stop) begin
          state_d = StIdle;
        end else if (sample_valid) begin
          din_d   = sample_in;
          state_d = StRecStb;
        end
      end
      StRecStb: begin
        if (stop) stop_pend_d = 1'b1;
        if (cnt_q == StbLast) begin
          cnt_d   = '0;
          state_d = StRecSettle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRecSettle: begin
        if (stop) stop_pend_d = 1'b1;
        if (cnt_q == '0 && count_q != CntMax) count_d = count_q + 1'b1;
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = (stop_pend_q || stop) ? StIdle : StRecWait;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPlayWait: begin
        stop_pend_d = 1'b0;
        cnt_d       = '0;
        if (fifo_empty) begin
          play_done_d = 1'b1;
          state_d     = StIdle;
        end else if (stop) begin
          state_d = StIdle;
        end else if (play_tick) begin
          state_d = StPlayStb;
        end
      end
      StPlayStb: begin
        if (stop) stop_pend_d = 1'b1;
        if (cnt_q == StbLast) begin
          cnt_d   = '0;
          state_d = StPlaySettle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPlaySettle: begin
        if (stop) stop_pend_d = 1'b1;
        if (cnt_q == SettleLast) begin
          // FIFO read data has had the whole settle window to arrive.
          sout_d     = fifo_dout;
          sout_vld_d = 1'b1;
          if (count_q != '0) count_d = count_q - 1'b1;
          cnt_d   = '0;
          state_d = (stop_pend_q || stop) ? StIdle : StPlayWait;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      din_q       <= '0;
      count_q     <= '0;
      sout_q      <= '0;
      sout_vld_q  <= 1'b0;
      rec_done_q  <= 1'b0;
      play_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      din_q       <= din_d;
      count_q     <= count_d;
      sout_q      <= sout_d;
      sout_vld_q  <= sout_vld_d;
      rec_done_q  <= rec_done_d;
      play_done_q <= play_done_d;
    end
  end

  always_comb begin
    mode = 2'b00;
    if (state_q == StRecWait || state_q == StRecStb || state_q == StRecSettle) begin
      mode = 2'b01;
    end else if (state_q == StPlayWait || state_q == StPlayStb || state_q == StPlaySettle) begin
      mode = 2'b10;
    end
  end

  assign fifo_wr          = (state_q == StRecStb);
  assign fifo_rd          = (state_q == StPlayStb);
  assign fifo_din         = din_q;
  assign sample_out       = sout_q;
  assign sample_out_valid = sout_vld_q;
  assign sample_count     = count_q;
  assign rec_done         = rec_done_q;
  assign play_done        = play_done_q;

`ifdef PCM_FIFO_CTRL_DROP_CNT_EN
  logic [7:0] drop_q;
  logic       drop_ev;

  always_comb begin
    drop_ev = 1'b0;
    if (sample_valid && (state_q == StRecStb || state_q == StRecSettle ||
                         (state_q == StRecWait && fifo_full))) begin
      drop_ev = 1'b1;
    end
    if (play_tick && (state_q == StPlayStb || state_q == StPlaySettle)) begin
      drop_ev = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_q <= '0;
    end else if (drop_ev && drop_q != 8'hff) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_pcm_fifo_ctrl.sv
// Directed bench for pcm_fifo_ctrl: cycle vector table plus playback/reset sequences.
module tb_pcm_fifo_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       rec_start, play_start, stop, sample_valid, play_tick;
  logic [7:0] sample_in;
  logic       fifo_wr, fifo_rd;
  logic [7:0] fifo_din, fifo_dout, sample_out;
  logic       fifo_empty, fifo_full;
  logic       sample_out_valid, rec_done, play_done;
  logic [1:0] mode;
  logic [6:0] sample_count;
`ifdef PCM_FIFO_CTRL_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  // Bench-side FIFO model, acting on strobe falling edges.
  logic       use_model;
  logic       tb_empty, tb_full;
  logic [7:0] mem[$];
  int         mcount;
  logic       wr_prev, rd_prev;
  logic [7:0] m_dout;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign fifo_empty = use_model ? (mcount == 0) : tb_empty;
  assign fifo_full  = use_model ? (mcount == 64) : tb_full;
  assign fifo_dout  = m_dout;

  always @(posedge clock) begin
    if (reset) begin
      mem.delete();
      mcount = 0;
      m_dout <= 8'h00;
    end else begin
      if (wr_prev && !fifo_wr) begin
        mem.push_back(fifo_din);
        mcount = mcount + 1;
      end
      if (rd_prev && !fifo_rd && mcount > 0) begin
        m_dout <= mem.pop_front();
        mcount = mcount - 1;
      end
    end
    wr_prev <= fifo_wr;
    rd_prev <= fifo_rd;
  end

  pcm_fifo_ctrl dut (
    .clock            (clock),
    .reset            (reset),
    .rec_start        (rec_start),
    .play_start       (play_start),
    .stop             (stop),
    .sample_in        (sample_in),
    .sample_valid     (sample_valid),
    .play_tick        (play_tick),
    .fifo_wr          (fifo_wr),
    .fifo_rd          (fifo_rd),
    .fifo_din         (fifo_din),
    .fifo_dout        (fifo_dout),
    .fifo_empty       (fifo_empty),
    .fifo_full        (fifo_full),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid),
    .mode             (mode),
    .sample_count     (sample_count),
    .rec_done         (rec_done),
    .play_done        (play_done)
`ifdef PCM_FIFO_CTRL_DROP_CNT_EN
    ,
    .drop_cnt         (drop_cnt)
`endif
  );

  typedef struct packed {
    logic       rs, ps, sp, sv;
    logic [7:0] sin;
    logic       pt, full, empty;
    logic       wr, rd;
    logic [7:0] din;
    logic [1:0] mode;
    logic [6:0] cnt;
    logic       rdone, pdone;
  } vec_t;

  function automatic vec_t mk(input int rs, ps, sp, sv, sin, pt, full, empty,
                              input int wr, rd, din, md, cnt, rdone, pdone);
    vec_t v;
    v.rs = rs[0]; v.ps = ps[0]; v.sp = sp[0]; v.sv = sv[0]; v.sin = sin[7:0];
    v.pt = pt[0]; v.full = full[0]; v.empty = empty[0];
    v.wr = wr[0]; v.rd = rd[0]; v.din = din[7:0]; v.mode = md[1:0];
    v.cnt = cnt[6:0]; v.rdone = rdone[0]; v.pdone = pdone[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    rec_start = 0; play_start = 0; stop = 0; sample_valid = 0; play_tick = 0;
    sample_in = 8'h00; tb_empty = 0; tb_full = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_in();
    repeat (3) cyc();
    reset = 0;
  endtask

  task automatic record(input logic [7:0] s);
    sample_valid = 1; sample_in = s;
    cyc();
    sample_valid = 0;
    repeat (8) cyc();
  endtask

  vec_t vecs[22];
  int   n;
  bit   seen_wr_rd;

  initial begin
    use_model = 0;
    do_reset();

    // Reset state after 10 idle cycles.
    seen_wr_rd = 0;
    repeat (10) begin
      cyc();
      if (fifo_wr || fifo_rd) seen_wr_rd = 1;
    end
    chk("idle_strobes", 32'(seen_wr_rd), 32'd0);
    chk("idle_mode", 32'(mode), 32'd0);
    chk("idle_count", 32'(sample_count), 32'd0);
    chk("idle_din", 32'(fifo_din), 32'd0);
    chk("idle_sout", 32'(sample_out), 32'd0);
    chk("idle_sout_valid", 32'(sample_out_valid), 32'd0);
    chk("idle_done", 32'({rec_done, play_done}), 32'd0);

    //               rs ps sp sv sin  pt fl em  wr rd din  md cnt rd pd
    vecs[0]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 1, 8'hA5, 0, 0, 0, 1, 0, 8'hA5, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'hA5, 1, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'hA5, 1, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'hA5, 1, 1, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'hA5, 1, 1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'hA5, 1, 1, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'hA5, 1, 1, 0, 0);
    vecs[8]  = mk(0, 0, 0, 1, 8'h5A, 0, 0, 0, 1, 0, 8'h5A, 1, 1, 0, 0);
    vecs[9]  = mk(0, 0, 0, 1, 8'h77, 0, 0, 0, 1, 0, 8'h5A, 1, 1, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h5A, 1, 1, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h5A, 1, 2, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h5A, 1, 2, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h5A, 1, 2, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h5A, 1, 2, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h5A, 0, 2, 1, 0);
    vecs[16] = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h5A, 0, 2, 0, 0);
    vecs[17] = mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h5A, 0, 2, 0, 1);
    vecs[18] = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h5A, 0, 2, 0, 0);
    vecs[19] = mk(1, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h5A, 0, 2, 0, 0);
    vecs[20] = mk(1, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h5A, 1, 2, 0, 0);
    vecs[21] = mk(0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h5A, 0, 2, 0, 0);

    for (int i = 0; i < 22; i++) begin
      rec_start = vecs[i].rs; play_start = vecs[i].ps; stop = vecs[i].sp;
      sample_valid = vecs[i].sv; sample_in = vecs[i].sin; play_tick = vecs[i].pt;
      tb_full = vecs[i].full; tb_empty = vecs[i].empty;
      cyc();
      chk($sformatf("v%0d_wr", i), 32'(fifo_wr), 32'(vecs[i].wr));
      chk($sformatf("v%0d_rd", i), 32'(fifo_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_din", i), 32'(fifo_din), 32'(vecs[i].din));
      chk($sformatf("v%0d_mode", i), 32'(mode), 32'(vecs[i].mode));
      chk($sformatf("v%0d_count", i), 32'(sample_count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_rec_done", i), 32'(rec_done), 32'(vecs[i].rdone));
      chk($sformatf("v%0d_play_done", i), 32'(play_done), 32'(vecs[i].pdone));
    end
    clear_in();
`ifdef PCM_FIFO_CTRL_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_cnt), 32'd1);
`endif

    // Record three samples and play them back through the FIFO model.
    use_model = 1;
    do_reset();
    rec_start = 1; cyc(); rec_start = 0;
    record(8'h11);
    record(8'h22);
    record(8'h33);
    stop = 1; cyc(); stop = 0;
    chk("rec3_count", 32'(sample_count), 32'd3);
    chk("rec3_mode", 32'(mode), 32'd0);
    play_start = 1; cyc(); play_start = 0;
    chk("play_mode", 32'(mode), 32'd2);
    for (int k = 0; k < 3; k++) begin
      play_tick = 1; cyc(); play_tick = 0;
      n = 1;
      while (!sample_out_valid && n < 20) begin
        cyc();
        n++;
      end
      chk($sformatf("play%0d_latency", k), 32'(n), 32'd7);
      chk($sformatf("play%0d_data", k), 32'(sample_out), 32'(8'h11 * (k + 1)));
      chk($sformatf("play%0d_count", k), 32'(sample_count), 32'(2 - k));
      if (k < 2) repeat (3) cyc();
    end
    n = 0;
    while (!play_done && n < 20) begin
      cyc();
      n++;
    end
    chk("play_done_seen", 32'(play_done), 32'd1);
    cyc();
    chk("play_end_mode", 32'(mode), 32'd0);
    chk("play_end_count", 32'(sample_count), 32'd0);
    chk("sout_hold", 32'(sample_out), 32'h33);

    // Reset while the read strobe is high.
    do_reset();
    rec_start = 1; cyc(); rec_start = 0;
    record(8'h3C);
    stop = 1; cyc(); stop = 0;
    play_start = 1; cyc(); play_start = 0;
    play_tick = 1; cyc(); play_tick = 0;
    chk("mid_rd_high", 32'(fifo_rd), 32'd1);
    reset = 1;
    cyc();
    chk("rst_rd_low", 32'(fifo_rd), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_count", 32'(sample_count), 32'd0);
    repeat (2) cyc();
    reset = 0;
    cyc();
    chk("post_rst_idle", 32'({fifo_wr, fifo_rd, mode}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
